multi_temp_monitor: RTL and testbench
=====================================

MULTI_TEMP_MONITOR -- requirements
Module: multi_temp_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, 4, number of temperature channels (1..16).
REQ-002 SHALL have parameter DATA_W, 8, unsigned sample width.
REQ-003 SHALL have parameters WARN_TH, 60 and FAULT_TH, 80, unsigned thresholds; WARN_TH < FAULT_TH is required.
REQ-004 SHALL have parameter HYST, 4, downward hysteresis in LSBs; HYST < WARN_TH is required.
REQ-005 SHALL have parameter DEBOUNCE, 3, consecutive valid samples needed for a non-fault transition (>= 1).
REQ-006 SHALL have ports: clk in 1 system clock; reset_n in 1 reset, asynchronous and active-low.
REQ-007 SHALL have ports: temp_data in NUM_CH*DATA_W channel samples, ch0 in LSBs; temp_valid in 1 all channels sampled this cycle; fault_clr in 1 request to leave FAULT.
REQ-008 SHALL have ports: system_state out 2 (IDLE=0, NORMAL=1, WARNING=2, FAULT=3); max_temp out DATA_W highest channel of last valid sample; fault_ch out NUM_CH one-hot-or-multi mask of faulting channels; norm_led, warn_led, falt_led out 1 each.

Function
REQ-009 Stage 1 SHALL register max_temp, plus a per-channel mask of samples >= FAULT_TH, one cycle after temp_valid; it SHALL hold its value when temp_valid=0.
REQ-010 Stage 2 SHALL update the FSM in the cycle after stage 1; it SHALL act only on samples qualified by the delayed valid.
REQ-011 IDLE SHALL go to NORMAL, WARNING or FAULT on the first qualified sample: max < WARN_TH, WARN_TH <= max < FAULT_TH, or max >= FAULT_TH respectively.
REQ-012 Target state SHALL be computed as follows.
  - From NORMAL: WARNING if max >= WARN_TH.
  - From WARNING: NORMAL if max < WARN_TH-HYST.
  - From any non-IDLE state: FAULT if max >= FAULT_TH.
  - Otherwise: the current state.
REQ-013 NORMAL<->WARNING transitions SHALL occur only after DEBOUNCE consecutive qualified samples with the same target.
  - The debounce counter SHALL clear when the target equals the current state or the candidate changes.
  - The counter SHALL be held, not cleared, on non-valid cycles.
REQ-014 Entry to FAULT SHALL bypass debounce and occur on the first qualifying sample.
REQ-015 On FAULT entry, fault_ch SHALL load the stage-1 fault mask; while in FAULT, further faulting channels SHALL be OR-ed in.
REQ-016 FAULT SHALL be latched; exit SHALL require fault_clr=1 in a cycle where the latest qualified max < FAULT_TH-HYST.
  - The exit SHALL go to NORMAL if max < WARN_TH-HYST, otherwise to WARNING.
  - fault_ch SHALL clear on exit.
REQ-017 If fault_clr coincides with a qualified sample >= FAULT_TH, the state SHALL remain FAULT; fault_clr outside FAULT SHALL be ignored.
REQ-018 LED outputs SHALL be registered decodes of system_state, one cycle after it changes.
  - IDLE: all LEDs off.
  - NORMAL: norm_led on.
  - WARNING: warn_led on.
  - FAULT: falt_led on.
  - Exactly one LED SHALL be on outside IDLE.
REQ-019 All comparisons SHALL be unsigned and done at DATA_W; WARN_TH-HYST and FAULT_TH-HYST SHALL be elaboration-time constants.

Reset
REQ-020 While reset_n=0, outputs SHALL be: system_state=IDLE, max_temp=0, fault_ch=0, all LEDs=0; the debounce counter, valid pipeline and blink counter SHALL be 0.
REQ-021 Reset assertion mid-operation, including during FAULT, SHALL clear all state immediately; operation SHALL resume from IDLE on the first qualified sample after release.

Configuration
REQ-022 With TEMP_MON_BLINK_EN defined, falt_led SHALL toggle every 2^BLINK_LOG2 cycles while in FAULT, starting on; BLINK_LOG2 is a parameter with default 4.
REQ-023 Without TEMP_MON_BLINK_EN, falt_led SHALL be steady on in FAULT, and no blink counter SHALL be synthesised.

Structure
REQ-024 State encoding (IDLE/NORMAL/WARNING/FAULT) and a state typedef SHALL live in shared package temp_mon_pkg.
REQ-025 Per-channel max and threshold-mask reduction SHALL be sub-module temp_max_tree, parametrised by NUM_CH and DATA_W.
REQ-026 The FSM, debounce and LED decode SHALL reside in multi_temp_monitor.

Verification (defaults)
REQ-027 Reset release, then one valid sample {50,40,30,20} -> system_state=NORMAL 2 cycles later; max_temp=50; norm_led=1 one cycle after that.
REQ-028 From NORMAL, apply samples with max 65: two samples -> remains NORMAL; third consecutive sample -> WARNING; an interleaved sample with max 55 -> counter restarts.
REQ-029 From WARNING, max 58 repeated -> stays WARNING (hysteresis); max 55 x3 -> NORMAL.
REQ-030 From NORMAL, single sample {10,85,90,10} -> FAULT on the first sample, fault_ch=4'b0110, falt_led=1.
REQ-031 In FAULT: fault_clr with max 78 -> stays FAULT; max 70 then fault_clr -> WARNING, fault_ch=0; fault_clr together with a valid sample of max 81 -> stays FAULT.
REQ-032 reset_n pulsed low mid-FAULT -> all outputs 0 asynchronously; next sample {30,30,30,30} -> NORMAL; with TEMP_MON_BLINK_EN, falt_led period is 32 cycles in FAULT.

Source files
------------

// File: rtl/temp_mon_pkg.sv
// -----------------------------------------------------------------------------
// temp_mon_pkg
// Shared definitions for the multi-channel temperature monitor.
//   state_t : system state encoding, also the value driven on system_state
//             (IDLE=0, NORMAL=1, WARNING=2, FAULT=3).
// -----------------------------------------------------------------------------
package temp_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_NORMAL  = 2'd1,
        ST_WARNING = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam int STATE_W = 2;

endpackage

// File: rtl/temp_max_tree.sv
// -----------------------------------------------------------------------------
// temp_max_tree
// Combinational reduction over NUM_CH unsigned samples: the maximum value and
// a per-channel mask of samples at or above threshold TH.
// Ports:
//   samples   in  NUM_CH*DATA_W  packed samples, channel 0 in the LSBs
//   max_val   out DATA_W         largest sample
//   over_mask out NUM_CH         bit i set when sample i >= TH
// -----------------------------------------------------------------------------
module temp_max_tree #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int TH     = 80
) (
    input  logic [NUM_CH*DATA_W-1:0] samples,
    output logic [DATA_W-1:0]        max_val,
    output logic [NUM_CH-1:0]        over_mask
);

    localparam logic [DATA_W-1:0] TH_W = DATA_W'(TH);

    // run_max[i] is the maximum of channels 0..i
    logic [DATA_W-1:0] run_max [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] ch_val;
            assign ch_val        = samples[gi*DATA_W +: DATA_W];
            assign over_mask[gi] = (ch_val >= TH_W);
            if (gi == 0) begin : g_first
                assign run_max[gi] = ch_val;
            end else begin : g_rest
                assign run_max[gi] = (ch_val > run_max[gi-1]) ? ch_val : run_max[gi-1];
            end
        end
    endgenerate

    assign max_val = run_max[NUM_CH-1];

endmodule

// File: rtl/multi_temp_monitor.sv
// -----------------------------------------------------------------------------
// multi_temp_monitor
// Two-stage temperature supervisor. Stage 1 registers the channel maximum and
// the over-fault-threshold mask of each valid sample; stage 2 runs the
// IDLE/NORMAL/WARNING/FAULT state machine with debounce and hysteresis.
// LEDs are registered decodes of the state.
// Optional feature macro: TEMP_MON_BLINK_EN -- falt_led blinks in FAULT with a
//   half period of 2^BLINK_LOG2 cycles, starting on.
// Ports:
//   clk          in  1               system clock
//   reset_n      in  1               asynchronous active-low reset
//   temp_data    in  NUM_CH*DATA_W   channel samples, ch0 in LSBs
//   temp_valid   in  1               all channels sampled this cycle
//   fault_clr    in  1               request to leave FAULT
//   system_state out 2               current state (temp_mon_pkg::state_t)
//   max_temp     out DATA_W          max channel of last valid sample
//   fault_ch     out NUM_CH          mask of channels that faulted
//   norm_led, warn_led, falt_led out 1 state indicators
// Parameter constraints: 1 <= NUM_CH <= 16, WARN_TH < FAULT_TH,
// HYST < WARN_TH, DEBOUNCE >= 1.
// -----------------------------------------------------------------------------
module multi_temp_monitor
    import temp_mon_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int WARN_TH  = 60,
    parameter int FAULT_TH = 80,
    parameter int HYST     = 4,
    parameter int DEBOUNCE = 3
`ifdef TEMP_MON_BLINK_EN
    ,parameter int BLINK_LOG2 = 4
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] temp_data,
    input  logic                     temp_valid,
    input  logic                     fault_clr,
    output logic [1:0]               system_state,
    output logic [DATA_W-1:0]        max_temp,
    output logic [NUM_CH-1:0]        fault_ch,
    output logic                     norm_led,
    output logic                     warn_led,
    output logic                     falt_led
);

    localparam logic [DATA_W-1:0] WARN_T   = DATA_W'(WARN_TH);
    localparam logic [DATA_W-1:0] FAULT_T  = DATA_W'(FAULT_TH);
    localparam logic [DATA_W-1:0] WARN_LO  = DATA_W'(WARN_TH - HYST);
    localparam logic [DATA_W-1:0] FAULT_LO = DATA_W'(FAULT_TH - HYST);
    localparam int                CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]  DEB_W    = CNT_W'(DEBOUNCE);

    // ---------------- stage 1: reduction + registers ----------------
    logic [DATA_W-1:0] tree_max;
    logic [NUM_CH-1:0] tree_mask;

    temp_max_tree #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .TH     (FAULT_TH)
    ) u_tree (
        .samples   (temp_data),
        .max_val   (tree_max),
        .over_mask (tree_mask)
    );

    logic [DATA_W-1:0] max_temp_reg;
    logic [NUM_CH-1:0] fault_mask_reg;
    logic              valid_d_reg;
    logic              clr_d_reg;

    // fault_clr travels with the sample it accompanied, so a clear request
    // arriving together with a hot sample is judged against that sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_temp_reg   <= '0;
            fault_mask_reg <= '0;
            valid_d_reg    <= 1'b0;
            clr_d_reg      <= 1'b0;
        end else begin
            valid_d_reg <= temp_valid;
            clr_d_reg   <= fault_clr;
            if (temp_valid) begin
                max_temp_reg   <= tree_max;
                fault_mask_reg <= tree_mask;
            end
        end
    end

    // ---------------- stage 2: state machine ----------------
    state_t            state_reg;
    state_t            cand_reg;
    logic [CNT_W-1:0]  deb_cnt_reg;
    logic [NUM_CH-1:0] fault_ch_reg;

    logic             is_hot;
    logic             is_warm;
    logic             below_warn_lo;
    logic             below_fault_lo;
    state_t           target;
    state_t           zone;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        is_hot         = (max_temp_reg >= FAULT_T);
        is_warm        = (max_temp_reg >= WARN_T);
        below_warn_lo  = (max_temp_reg <  WARN_LO);
        below_fault_lo = (max_temp_reg <  FAULT_LO);

        // Zone without hysteresis, used when leaving IDLE
        zone = is_hot ? ST_FAULT : (is_warm ? ST_WARNING : ST_NORMAL);

        target = state_reg;
        case (state_reg)
            ST_NORMAL:  if (is_warm)       target = ST_WARNING;
            ST_WARNING: if (below_warn_lo) target = ST_NORMAL;
            default:    target = state_reg;
        endcase
        if ((state_reg != ST_IDLE) && is_hot) target = ST_FAULT;

        // A new candidate starts a fresh run of one sample
        cnt_inc = (target == cand_reg) ? deb_cnt_reg + 1'b1 : CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            cand_reg     <= ST_IDLE;
            deb_cnt_reg  <= '0;
            fault_ch_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (valid_d_reg) begin
                        state_reg    <= zone;
                        cand_reg     <= zone;
                        deb_cnt_reg  <= '0;
                        fault_ch_reg <= is_hot ? fault_mask_reg : '0;
                    end
                end
                ST_NORMAL, ST_WARNING: begin
                    if (valid_d_reg) begin
                        if (target == ST_FAULT) begin
                            state_reg    <= ST_FAULT;
                            cand_reg     <= ST_FAULT;
                            deb_cnt_reg  <= '0;
                            fault_ch_reg <= fault_mask_reg;
                        end else if (target == state_reg) begin
                            cand_reg    <= state_reg;
                            deb_cnt_reg <= '0;
                        end else if (cnt_inc >= DEB_W) begin
                            state_reg   <= target;
                            cand_reg    <= target;
                            deb_cnt_reg <= '0;
                        end else begin
                            cand_reg    <= target;
                            deb_cnt_reg <= cnt_inc;
                        end
                    end
                end
                default: begin // ST_FAULT, latched until cleared
                    if (clr_d_reg && below_fault_lo) begin
                        state_reg    <= below_warn_lo ? ST_NORMAL : ST_WARNING;
                        cand_reg     <= below_warn_lo ? ST_NORMAL : ST_WARNING;
                        deb_cnt_reg  <= '0;
                        fault_ch_reg <= '0;
                    end else if (valid_d_reg) begin
                        fault_ch_reg <= fault_ch_reg | fault_mask_reg;
                    end
                end
            endcase
        end
    end

    // ---------------- LED decode ----------------
    logic blink_on;

`ifdef TEMP_MON_BLINK_EN
    logic [BLINK_LOG2-1:0] blink_cnt_reg;
    logic                  blink_phase_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (state_reg != ST_FAULT) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
            if (&blink_cnt_reg) blink_phase_reg <= ~blink_phase_reg;
        end
    end

    assign blink_on = ~blink_phase_reg;
`else
    assign blink_on = 1'b1;
`endif

    logic norm_led_reg;
    logic warn_led_reg;
    logic falt_led_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            norm_led_reg <= 1'b0;
            warn_led_reg <= 1'b0;
            falt_led_reg <= 1'b0;
        end else begin
            norm_led_reg <= (state_reg == ST_NORMAL);
            warn_led_reg <= (state_reg == ST_WARNING);
            falt_led_reg <= (state_reg == ST_FAULT) && blink_on;
        end
    end

    assign system_state = state_reg;
    assign max_temp     = max_temp_reg;
    assign fault_ch     = fault_ch_reg;
    assign norm_led     = norm_led_reg;
    assign warn_led     = warn_led_reg;
    assign falt_led     = falt_led_reg;

endmodule

// File: tb/tb_multi_temp_monitor.sv
// -----------------------------------------------------------------------------
// tb_multi_temp_monitor
// Directed bench for multi_temp_monitor with default parameters
// (WARN_TH=60, FAULT_TH=80, HYST=4 -> exit levels 56 / 76, DEBOUNCE=3).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// A sample presented at falling edge N shows on max_temp at N+1, on
// system_state at N+2 and on the LEDs at N+3. fault_clr follows the same
// pipeline as a sample.
// -----------------------------------------------------------------------------
module tb_multi_temp_monitor;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_CH*DATA_W-1:0] temp_data;
    logic                     temp_valid;
    logic                     fault_clr;
    logic [1:0]               system_state;
    logic [DATA_W-1:0]        max_temp;
    logic [NUM_CH-1:0]        fault_ch;
    logic                     norm_led;
    logic                     warn_led;
    logic                     falt_led;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    multi_temp_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .temp_data    (temp_data),
        .temp_valid   (temp_valid),
        .fault_clr    (fault_clr),
        .system_state (system_state),
        .max_temp     (max_temp),
        .fault_ch     (fault_ch),
        .norm_led     (norm_led),
        .warn_led     (warn_led),
        .falt_led     (falt_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-18s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-18s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One valid sample (channel 0 first), optionally with fault_clr.
    // Called at a falling edge, returns at the next falling edge.
    task automatic send(input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic [7:0] c3,
                        input logic clr);
        temp_data  = {c3, c2, c1, c0};
        temp_valid = 1'b1;
        fault_clr  = clr;
        @(negedge clk);
        temp_valid = 1'b0;
        fault_clr  = 1'b0;
    endtask

    task automatic clr_pulse();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        temp_data  = '0;
        temp_valid = 1'b0;
        fault_clr  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state", 32'(system_state), 0);
        check("rst_max",   32'(max_temp), 0);
        check("rst_fch",   32'(fault_ch), 0);
        check("rst_leds",  32'({norm_led, warn_led, falt_led}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_hold", 32'(system_state), 0);

        // First sample from IDLE -> NORMAL
        send(50, 40, 30, 20, 1'b0);
        check("first_max", 32'(max_temp), 50);
        settle();
        check("first_state", 32'(system_state), 1);
        settle();
        check("first_leds", 32'({norm_led, warn_led, falt_led}), 3'b100);

        // Debounce NORMAL -> WARNING with an interrupted run
        send(65, 10, 10, 10, 1'b0);
        send(10, 65, 10, 10, 1'b0);
        settle();
        check("deb_two", 32'(system_state), 1);
        send(55, 10, 10, 10, 1'b0);
        send(65, 10, 10, 10, 1'b0);
        send(65, 10, 10, 10, 1'b0);
        settle();
        check("deb_restart", 32'(system_state), 1);
        send(65, 10, 10, 10, 1'b0);
        settle();
        check("deb_third", 32'(system_state), 2);
        settle();
        check("warn_leds", 32'({norm_led, warn_led, falt_led}), 3'b010);

        // Hysteresis: 58 stays WARNING, 55 x3 returns to NORMAL
        repeat (4) send(58, 10, 10, 10, 1'b0);
        settle();
        check("hyst_58", 32'(system_state), 2);
        send(55, 10, 10, 10, 1'b0);
        send(55, 10, 10, 10, 1'b0);
        settle();
        check("hyst_55x2", 32'(system_state), 2);
        send(55, 10, 10, 10, 1'b0);
        settle();
        check("hyst_55x3", 32'(system_state), 1);

        // fault_clr outside FAULT has no effect
        clr_pulse();
        settle();
        check("clr_ignored", 32'(system_state), 1);

        // Immediate FAULT entry, mask load
        send(10, 85, 90, 10, 1'b0);
        settle();
        check("fault_state", 32'(system_state), 3);
        check("fault_mask", 32'(fault_ch), 4'b0110);
        settle();
        check("fault_leds", 32'({norm_led, warn_led, falt_led}), 3'b001);

        // Further faulting channel is accumulated
        send(10, 10, 10, 82, 1'b0);
        settle();
        check("fault_or", 32'(fault_ch), 4'b1110);

        // Clear with max 78 (not below 76) is refused
        send(78, 10, 10, 10, 1'b1);
        settle();
        check("clr_78", 32'(system_state), 3);

        // Max 70 then clear -> WARNING, mask cleared
        send(70, 10, 10, 10, 1'b0);
        clr_pulse();
        settle();
        check("clr_to_warn", 32'(system_state), 2);
        check("clr_fch", 32'(fault_ch), 0);

        // Clear together with a hot sample keeps FAULT
        send(81, 10, 10, 10, 1'b1);
        settle();
        check("hot81_enter", 32'(system_state), 3);
        check("hot81_fch", 32'(fault_ch), 4'b0001);
        send(81, 10, 10, 10, 1'b1);
        settle();
        check("hot81_clr", 32'(system_state), 3);

        // Cool sample then clear -> NORMAL
        send(50, 10, 10, 10, 1'b0);
        clr_pulse();
        settle();
        check("clr_to_norm", 32'(system_state), 1);

        // Reset mid-FAULT clears everything asynchronously
        send(10, 85, 90, 10, 1'b0);
        settle();
        check("refault", 32'(system_state), 3);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", 32'(system_state), 0);
        check("arst_max",   32'(max_temp), 0);
        check("arst_fch",   32'(fault_ch), 0);
        check("arst_leds",  32'({norm_led, warn_led, falt_led}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(system_state), 0);
        send(30, 30, 30, 30, 1'b0);
        check("post_rst_max", 32'(max_temp), 30);
        settle();
        check("post_rst_norm", 32'(system_state), 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
